// File: rtl/aes_round_engine.sv
// +----------------------------------------------------------------------------+
// | aes_round_engine : iterative AES enc/dec datapath with word S-boxes | rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_round_pkg;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sub_fwd(input logic [7:0] b);
    logic [7:0] g;
    g = ginv(b);
    return g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sub_inv(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    if (!inv)
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return o;
  endfunction

  // Byte 4c+r sits at column c, row r; row r rotates left by r (right when inverse).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction
endpackage

module sbox (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = aes_round_pkg::sub_fwd(word_i[8*b +: 8]);
  end
endmodule

module aes_sbox_inv (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = aes_round_pkg::sub_inv(word_i[8*b +: 8]);
  end
endmodule

module aes_round_engine #(
  parameter int NUM_ROUNDS = 10,
  parameter int SBOX_WORDS = 1,
  parameter int RIDX_W     = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              key_ready,
  output logic [RIDX_W-1:0] rk_round,
  input  logic [127:0]      rk_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [127:0]      in_block,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [127:0]      out_block,
  output logic              busy
);
  import aes_round_pkg::*;

  localparam int                c_SUBC   = 4 / SBOX_WORDS;
  localparam logic [1:0]        c_LAST_K = 2'(c_SUBC - 1);
  localparam logic [RIDX_W-1:0] c_NR     = RIDX_W'(NUM_ROUNDS);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
    $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
  end
  if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_words
    $error("aes_round_engine: SBOX_WORDS must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SUB, S_LIN, S_OUT} state_t;

  state_t            fsm_q;
  logic [RIDX_W-1:0] round_q;
  logic [1:0]        k_q;
  logic [127:0]      state_q, state_d;
  logic              mode_q;
  logic [127:0]      out_block_q;
  logic              out_valid_q, out_mode_q;

  logic [31:0]  w_words   [4];
  logic [31:0]  w_fwd_out [SBOX_WORDS];
  logic [31:0]  w_inv_out [SBOX_WORDS];
  logic [127:0] w_t, w_lin;
  logic         w_last;

  for (genvar w = 0; w < 4; w++) begin : g_words
    assign w_words[w] = state_q[127-32*w -: 32];
  end

  for (genvar j = 0; j < SBOX_WORDS; j++) begin : g_sbox
    logic [1:0] w_widx;
    assign w_widx = 2'(int'(k_q) * SBOX_WORDS + j);
    sbox         u_fwd (.word_i(w_words[w_widx]), .word_o(w_fwd_out[j]));
    aes_sbox_inv u_inv (.word_i(w_words[w_widx]), .word_o(w_inv_out[j]));
  end

  always_comb begin
    state_d = state_q;
    for (int w = 0; w < 4; w++) begin
      if (k_q == 2'(w / SBOX_WORDS))
        state_d[127-32*w -: 32] = mode_q ? w_inv_out[w % SBOX_WORDS] : w_fwd_out[w % SBOX_WORDS];
    end
  end

  // Decrypt adds the key before InvMixColumns so the same round-key table serves both modes.
  always_comb begin
    w_last = (round_q == c_NR);
    if (!mode_q) begin
      w_t   = shift_rows(state_q, 1'b0);
      w_lin = (w_last ? w_t : mix_columns(w_t, 1'b0)) ^ rk_data;
    end else begin
      w_t   = shift_rows(state_q, 1'b1) ^ rk_data;
      w_lin = w_last ? w_t : mix_columns(w_t, 1'b1);
    end
  end

  always_comb begin
    rk_round = '0;
    case (fsm_q)
      S_INIT:       rk_round = mode_q ? c_NR : '0;
      S_SUB, S_LIN: rk_round = mode_q ? (c_NR - round_q) : round_q;
      default:      rk_round = '0;
    endcase
  end

  assign in_ready  = (fsm_q == S_IDLE) && key_ready && !areset;
  assign busy      = (fsm_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_block = out_block_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      fsm_q       <= S_IDLE;
      round_q     <= '0;
      k_q         <= '0;
      state_q     <= '0;
      mode_q      <= 1'b0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: if (in_valid && in_ready) begin
          state_q <= in_block;
          mode_q  <= in_mode;
          fsm_q   <= S_INIT;
        end
        S_INIT: begin
          state_q <= state_q ^ rk_data;
          round_q <= RIDX_W'(1);
          k_q     <= '0;
          fsm_q   <= S_SUB;
        end
        S_SUB: begin
          state_q <= state_d;
          if (k_q == c_LAST_K) begin
            k_q   <= '0;
            fsm_q <= S_LIN;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        S_LIN: begin
          state_q <= w_lin;
          if (w_last) begin
            out_block_q <= w_lin;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
            fsm_q       <= S_OUT;
          end else begin
            round_q <= round_q + RIDX_W'(1);
            fsm_q   <= S_SUB;
          end
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          fsm_q       <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_aes_round_engine.sv
// +----------------------------------------------------------------------------+
// | tb_aes_round_engine : directed FIPS-197 vectors on three engine builds | rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_round_engine;
  localparam logic [127:0] c_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] c_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] c_KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk, areset, key_ready;
  logic [3:0]   rk_round  [3];
  logic [127:0] rk_data   [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         in_mode   [3];
  logic [127:0] in_block  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         out_mode  [3];
  logic [127:0] out_block [3];
  logic         busy      [3];

  logic [127:0] rk128 [16];
  logic [127:0] rk256 [16];
  logic [7:0]   sb    [256];
  int n_assert, n_fail;

  assign rk_data[0] = rk128[rk_round[0]];
  assign rk_data[1] = rk128[rk_round[1]];
  assign rk_data[2] = rk256[rk_round[2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_engine #(.NUM_ROUNDS(10), .SBOX_WORDS(1), .RIDX_W(4)) u_dut_w1 (
    .aclk(clk), .areset(areset), .key_ready(key_ready), .rk_round(rk_round[0]), .rk_data(rk_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]), .in_block(in_block[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_mode(out_mode[0]),
    .out_block(out_block[0]), .busy(busy[0]));

  aes_round_engine #(.NUM_ROUNDS(10), .SBOX_WORDS(4), .RIDX_W(4)) u_dut_w4 (
    .aclk(clk), .areset(areset), .key_ready(key_ready), .rk_round(rk_round[1]), .rk_data(rk_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]), .in_block(in_block[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_mode(out_mode[1]),
    .out_block(out_block[1]), .busy(busy[1]));

  aes_round_engine #(.NUM_ROUNDS(14), .SBOX_WORDS(1), .RIDX_W(4)) u_dut_nr14 (
    .aclk(clk), .areset(areset), .key_ready(key_ready), .rk_round(rk_round[2]), .rk_data(rk_data[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]), .in_block(in_block[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_mode(out_mode[2]),
    .out_block(out_block[2]), .busy(busy[2]));

  function automatic logic [7:0] tb_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  // Round keys are stimulus standing in for aes_key_gen, so the S-box is built by brute-force inverse search.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int sel);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++) begin
      if (sel == 0) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input int d, input logic mode, input logic [127:0] blk,
                           input logic [127:0] exp_blk, input int lat, input int subc,
                           input int nr, input int hold, input string tag);
    int cyc, r, waits;
    waits = 0;
    while (!in_ready[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, " in_ready before accept"}, 128'(in_ready[d]), 128'd1);
    in_valid[d] = 1'b1;
    in_mode[d]  = mode;
    in_block[d] = blk;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_block[d] = '0;
    cyc = 1;
    chk({tag, " rk_round init"}, 128'(rk_round[d]), mode ? 128'(nr) : 128'd0);
    while (!out_valid[d] && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((cyc - 1) % (subc + 1) == 0) begin
        r = (cyc - 1) / (subc + 1);
        if (r >= 1 && r <= nr)
          chk($sformatf("%s rk_round lin r%0d", tag, r), 128'(rk_round[d]), mode ? 128'(nr - r) : 128'(r));
      end
    end
    chk({tag, " latency"}, 128'(cyc), 128'(lat));
    chk({tag, " out_block"}, out_block[d], exp_blk);
    chk({tag, " out_mode"}, 128'(out_mode[d]), 128'(mode));
    chk({tag, " busy in out"}, 128'(busy[d]), 128'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s hold %0d block", tag, h), out_block[d], exp_blk);
      chk($sformatf("%s hold %0d in_ready/out_valid", tag, h), 128'({in_ready[d], out_valid[d]}), 128'b01);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk({tag, " out_valid after take"}, 128'(out_valid[d]), 128'd0);
    chk({tag, " idle after take"}, 128'({busy[d], in_ready[d]}), 128'b01);
  endtask

  initial begin
    logic seen;
    n_assert = 0;
    n_fail   = 0;
    areset    = 1'b1;
    key_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_mode[d] = 1'b0; in_block[d] = '0; out_ready[d] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      rk128[i] = '0;
      rk256[i] = '0;
    end
    build_sbox();
    expand({c_KEY128, 128'h0}, 4, 0);
    expand(c_KEY256, 8, 1);

    repeat (3) @(negedge clk);
    chk("reset in_ready", 128'(in_ready[0]), 128'd0);
    chk("reset busy", 128'(busy[0]), 128'd0);
    chk("reset out_valid", 128'(out_valid[0]), 128'd0);
    chk("reset out_block", out_block[0], 128'd0);
    chk("reset out_mode", 128'(out_mode[0]), 128'd0);
    chk("reset rk_round", 128'(rk_round[0]), 128'd0);
    areset = 1'b0;
    @(negedge clk);

    run_block(0, 1'b0, c_PT,    c_CT128, 52, 4, 10, 0, "T1 enc128");
    run_block(0, 1'b1, c_CT128, c_PT,    52, 4, 10, 0, "T2 dec128");
    run_block(1, 1'b0, c_PT,    c_CT128, 22, 1, 10, 0, "T3 enc128 w4");
    run_block(1, 1'b1, c_CT128, c_PT,    22, 1, 10, 0, "T3 dec128 w4");
    run_block(2, 1'b0, c_PT,    c_CT256, 72, 4, 14, 0, "T4 enc256");
    run_block(2, 1'b1, c_CT256, c_PT,    72, 4, 14, 0, "T4 dec256");
    run_block(0, 1'b0, c_PT,    c_CT128, 52, 4, 10, 20, "T5 enc hold");
    run_block(0, 1'b1, c_CT128, c_PT,    52, 4, 10, 0, "T5 dec b2b");

    // Abort a block in round 5: cycles 22..25 are its S-box cycles on the W=1 build.
    in_valid[0] = 1'b1;
    in_mode[0]  = 1'b0;
    in_block[0] = c_PT;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (22) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk("T6 busy after reset", 128'(busy[0]), 128'd0);
    chk("T6 out_valid after reset", 128'(out_valid[0]), 128'd0);
    chk("T6 in_ready during reset", 128'(in_ready[0]), 128'd0);
    chk("T6 out_block after reset", out_block[0], 128'd0);
    areset = 1'b0;
    #1;
    chk("T6 in_ready after release", 128'(in_ready[0]), 128'd1);
    key_ready   = 1'b0;
    in_valid[0] = 1'b1;
    in_block[0] = c_PT;
    #1;
    chk("T6 in_ready key_ready low", 128'(in_ready[0]), 128'd0);
    repeat (4) @(negedge clk);
    chk("T6 no accept without keys", 128'(busy[0]), 128'd0);
    in_valid[0] = 1'b0;
    key_ready   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) seen = 1'b1;
    end
    chk("T6 aborted block silent", 128'(seen), 128'd0);
    run_block(0, 1'b0, c_PT, c_CT128, 52, 4, 10, 0, "T6 recover enc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
